// File: rtl/spi_slv.sv
// spi_slv: SPI mode-0 slave that receives 16-bit commands and returns a 16-bit response word.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   SCLK, SS_n, MOSI   : SPI master signals, asynchronous to clk
//   MISO               : serial response, MSB first
//   resp_data/wrt_resp : response word and its load strobe (honoured only while idle)
//   cmd/cmd_rdy        : last complete 16-bit command and its valid flag
//   clr_cmd_rdy        : strobe consuming cmd
//   frm_err            : sticky wrong-length frame flag, active only with SPI_SLV_FRAME_CHK_EN defined
module spi_slv (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [15:0] resp_data,
   input  logic        wrt_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        frm_err
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      r_state, w_nxt;
   logic [2:0]  r_sclk_ff, r_ss_ff;
   logic [1:0]  r_mosi_ff;
   logic [4:0]  r_cnt;
   logic [15:0] r_rx, r_tx;
   logic        r_live, r_armed;
   logic        w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_start, w_good;

   assign w_sclk_rise = r_sclk_ff[1] & ~r_sclk_ff[2];
   assign w_sclk_fall = ~r_sclk_ff[1] & r_sclk_ff[2];
   assign w_ss_fall   = ~r_ss_ff[1] & r_ss_ff[2];
   assign w_ss_rise   = r_ss_ff[1] & ~r_ss_ff[2];
   // The SS_n synchronizer resets to 1, so a master still holding SS_n low across
   // reset would look like a fresh fall; frames start only once SS_n was seen high.
   assign w_start     = (r_state == IDLE) & w_ss_fall & r_armed;
   assign w_good      = (r_state == DONE) & (r_cnt == 5'd16);
   assign MISO        = r_tx[15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_ff <= 3'b000;
         r_ss_ff   <= 3'b111;
         r_mosi_ff <= 2'b00;
         r_state   <= IDLE;
      end else begin
         r_sclk_ff <= {r_sclk_ff[1:0], SCLK};
         r_ss_ff   <= {r_ss_ff[1:0], SS_n};
         r_mosi_ff <= {r_mosi_ff[0], MOSI};
         r_state   <= w_nxt;
      end
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    w_nxt = w_start ? SHIFT : IDLE;
         SHIFT:   w_nxt = w_ss_rise ? DONE : SHIFT;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live  <= 1'b0;
         r_armed <= 1'b0;
         r_cnt   <= 5'd0;
         r_rx    <= 16'h0000;
         r_tx    <= 16'h0000;
         cmd     <= 16'h0000;
         cmd_rdy <= 1'b0;
      end else begin
         // r_live delays arming until the first synchronizer stage holds a real sample
         r_live <= 1'b1;
         if (r_live & r_ss_ff[0])
            r_armed <= 1'b1;
         if (w_start)
            r_cnt <= 5'd0;
         else if ((r_state == SHIFT) && w_sclk_rise && (r_cnt != 5'd31))
            r_cnt <= r_cnt + 5'd1;
         if ((r_state == SHIFT) && w_sclk_rise)
            r_rx <= {r_rx[14:0], r_mosi_ff[1]};
         if ((r_state == IDLE) && wrt_resp)
            r_tx <= resp_data;
         else if ((r_state == SHIFT) && w_sclk_fall)
            r_tx <= {r_tx[14:0], 1'b0};
         if (w_good) begin
            cmd     <= r_rx;
            cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy)
            cmd_rdy <= 1'b0;
      end
   end

`ifdef SPI_SLV_FRAME_CHK_EN
   logic r_frm_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_frm_err <= 1'b0;
      else if ((r_state == DONE) && (r_cnt != 5'd16))
         r_frm_err <= 1'b1;
   end
   assign frm_err = r_frm_err;
`else
   assign frm_err = 1'b0;
`endif
endmodule
